// File: rtl/porta_pad_pkg.sv
// Shared constants for the serial gamepad poller: bit order, keypad codes, FSM encoding,
// and the frame-commit filter.
package porta_pad_pkg;

  localparam int unsigned BIT_B      = 0;
  localparam int unsigned BIT_Y      = 1;
  localparam int unsigned BIT_SELECT = 2;
  localparam int unsigned BIT_START  = 3;
  localparam int unsigned BIT_UP     = 4;
  localparam int unsigned BIT_DOWN   = 5;
  localparam int unsigned BIT_LEFT   = 6;
  localparam int unsigned BIT_RIGHT  = 7;
  localparam int unsigned BIT_A      = 8;
  localparam int unsigned BIT_X      = 9;
  localparam int unsigned BIT_L      = 10;
  localparam int unsigned BIT_R      = 11;
  localparam int unsigned BIT_ID_LO  = 12;

  localparam int unsigned NumBits = 16;
  localparam int unsigned NumBtns = 12;

  localparam logic [3:0] KEY_START  = 4'b1101;
  localparam logic [3:0] KEY_SELECT = 4'b0111;
  localparam logic [3:0] KEY_NONE   = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StClkLo,
    StClkHi,
    StDone
  } pad_state_e;

  function automatic logic frame_valid(input logic [NumBits-1:0] raw);
    return &raw[NumBits-1:BIT_ID_LO];
  endfunction

  // Active-low in, active-low out. A bad id forces all released; opposing directions cancel.
  function automatic logic [NumBtns-1:0] commit_btns(input logic [NumBits-1:0] raw);
    logic [NumBtns-1:0] b;
    b = '1;
    if (frame_valid(raw)) begin
      b = raw[NumBtns-1:0];
      if (!b[BIT_UP] && !b[BIT_DOWN]) begin
        b[BIT_UP]   = 1'b1;
        b[BIT_DOWN] = 1'b1;
      end
      if (!b[BIT_LEFT] && !b[BIT_RIGHT]) begin
        b[BIT_LEFT]  = 1'b1;
        b[BIT_RIGHT] = 1'b1;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/porta_pad_mux.sv
// Per-player controller-line mux: joystick or keypad view of the committed buttons,
// selected by the glue's active-low commons.
module porta_pad_mux
  import porta_pad_pkg::*;
(
  input  logic [NumBtns-1:0] btn_n_i,
  input  logic               sel_key_ni,
  input  logic               sel_joy_ni,
  output logic [3:0]         line_o,
  output logic               fire_o
);

  logic unused_btns;
  assign unused_btns = ^{btn_n_i[BIT_Y], btn_n_i[BIT_X], btn_n_i[BIT_L], btn_n_i[BIT_R]};

  always_comb begin
    line_o = 4'b1111;
    fire_o = 1'b1;
    if (!sel_joy_ni && sel_key_ni) begin
      line_o = {btn_n_i[BIT_RIGHT], btn_n_i[BIT_LEFT], btn_n_i[BIT_DOWN], btn_n_i[BIT_UP]};
      fire_o = btn_n_i[BIT_B];
    end else if (!sel_key_ni && sel_joy_ni) begin
      if (!btn_n_i[BIT_START]) begin
        line_o = KEY_START;
      end else if (!btn_n_i[BIT_SELECT]) begin
        line_o = KEY_SELECT;
      end else begin
        line_o = KEY_NONE;
      end
      fire_o = btn_n_i[BIT_A];
    end
  end

endmodule

// File: rtl/porta_pad_serial.sv
// Polls two SNES-style serial pads once per frame period and presents Coleco-style
// active-low controller lines for both players.
module porta_pad_serial
  import porta_pad_pkg::*;
#(
  parameter int unsigned POLL_CYCLES  = 59659,
  parameter int unsigned LATCH_CYCLES = 43,
  parameter int unsigned HALF_CYCLES  = 22
) (
  input  logic clk,
  input  logic RESETn,
  output logic PAD_LATCH,
  output logic PAD_CLK,
  input  logic PAD1_DATA,
  input  logic PAD2_DATA,
  input  logic C1_4,
  input  logic C2_4,
  input  logic C1_7,
  input  logic C2_7,
  output logic C1_0,
  output logic C1_1,
  output logic C1_2,
  output logic C1_3,
  output logic C1_5,
  output logic C1_6,
  output logic C1_8,
  output logic C2_0,
  output logic C2_1,
  output logic C2_2,
  output logic C2_3,
  output logic C2_5,
  output logic C2_6,
  output logic C2_8,
  output logic PAD1_VALID,
  output logic PAD2_VALID,
  output logic FRAME_STB
);

  localparam int unsigned FrameLen = LATCH_CYCLES + 30 * HALF_CYCLES + 1;
  localparam int unsigned PollW    = $clog2(POLL_CYCLES);
  localparam int unsigned TmrMax   = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned TmrW     = $clog2(TmrMax) + 1;

  if (POLL_CYCLES <= FrameLen) begin : gen_poll_chk
    $error("POLL_CYCLES must exceed the frame length");
  end

  pad_state_e         state_q, state_d;
  logic [PollW-1:0]   poll_q, poll_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [3:0]         bit_q, bit_d;
  logic [NumBits-1:0] shd1_q, shd1_d, shd2_q, shd2_d;
  logic [NumBtns-1:0] btn1_q, btn1_d, btn2_q, btn2_d;
  logic               vld1_q, vld1_d, vld2_q, vld2_d;
  logic [1:0]         sync1_q, sync2_q;
  logic               poll_wrap;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StIdle;
      poll_q  <= '0;
      tmr_q   <= '0;
      bit_q   <= '0;
      shd1_q  <= '1;
      shd2_q  <= '1;
      btn1_q  <= '1;
      btn2_q  <= '1;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shd1_q  <= shd1_d;
      shd2_q  <= shd2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      sync1_q <= {sync1_q[0], PAD1_DATA};
      sync2_q <= {sync2_q[0], PAD2_DATA};
    end
  end

  assign poll_wrap = (poll_q == PollW'(POLL_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    poll_d  = poll_wrap ? '0 : poll_q + PollW'(1);
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shd1_d  = shd1_q;
    shd2_d  = shd2_q;
    btn1_d  = btn1_q;
    btn2_d  = btn2_q;
    vld1_d  = vld1_q;
    vld2_d  = vld2_q;
    unique case (state_q)
      StIdle: begin
        if (poll_wrap) begin
          state_d = StLatch;
          tmr_d   = '0;
        end
      end
      StLatch: begin
        if (tmr_q == TmrW'(LATCH_CYCLES - 1)) begin
          shd1_d[BIT_B] = sync1_q[1];
          shd2_d[BIT_B] = sync2_q[1];
          tmr_d         = '0;
          bit_d         = 4'd1;
          state_d       = StClkLo;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StClkLo: begin
        if (tmr_q == TmrW'(HALF_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StClkHi;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StClkHi: begin
        if (tmr_q == TmrW'(HALF_CYCLES - 1)) begin
          shd1_d[bit_q] = sync1_q[1];
          shd2_d[bit_q] = sync2_q[1];
          tmr_d         = '0;
          if (bit_q == 4'd15) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = StClkLo;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StDone: begin
        btn1_d  = commit_btns(shd1_q);
        btn2_d  = commit_btns(shd2_q);
        vld1_d  = frame_valid(shd1_q);
        vld2_d  = frame_valid(shd2_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign PAD_LATCH  = (state_q == StLatch);
  assign PAD_CLK    = (state_q != StClkLo);
  assign FRAME_STB  = (state_q == StDone);
  assign PAD1_VALID = vld1_q;
  assign PAD2_VALID = vld2_q;

  logic [3:0] c1_line, c2_line;

  porta_pad_mux u_mux1 (
    .btn_n_i    (btn1_q),
    .sel_key_ni (C1_4),
    .sel_joy_ni (C1_7),
    .line_o     (c1_line),
    .fire_o     (C1_5)
  );

  porta_pad_mux u_mux2 (
    .btn_n_i    (btn2_q),
    .sel_key_ni (C2_4),
    .sel_joy_ni (C2_7),
    .line_o     (c2_line),
    .fire_o     (C2_5)
  );

  assign {C1_3, C1_2, C1_1, C1_0} = c1_line;
  assign {C2_3, C2_2, C2_1, C2_0} = c2_line;
  assign C1_6 = 1'b1;
  assign C1_8 = 1'b1;
  assign C2_6 = 1'b1;
  assign C2_8 = 1'b1;

endmodule

// File: tb/tb_porta_pad_serial.sv
// Directed bench for porta_pad_serial: frame timing, table of pad words/selects with
// hand-computed controller lines, and a mid-frame reset sequence.
module tb_porta_pad_serial;

  localparam int unsigned Poll  = 1000;
  localparam int unsigned Latch = 43;
  localparam int unsigned Half  = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pad_latch, pad_clk, pad1_data, pad2_data;
  logic c1_4, c2_4, c1_7, c2_7;
  logic c1_0, c1_1, c1_2, c1_3, c1_5, c1_6, c1_8;
  logic c2_0, c2_1, c2_2, c2_3, c2_5, c2_6, c2_8;
  logic v1, v2, stb;

  always #5 clk = ~clk;

  porta_pad_serial #(
    .POLL_CYCLES  (Poll),
    .LATCH_CYCLES (Latch),
    .HALF_CYCLES  (Half)
  ) dut (
    .clk        (clk),
    .RESETn     (rst_n),
    .PAD_LATCH  (pad_latch),
    .PAD_CLK    (pad_clk),
    .PAD1_DATA  (pad1_data),
    .PAD2_DATA  (pad2_data),
    .C1_4       (c1_4),
    .C2_4       (c2_4),
    .C1_7       (c1_7),
    .C2_7       (c2_7),
    .C1_0       (c1_0),
    .C1_1       (c1_1),
    .C1_2       (c1_2),
    .C1_3       (c1_3),
    .C1_5       (c1_5),
    .C1_6       (c1_6),
    .C1_8       (c1_8),
    .C2_0       (c2_0),
    .C2_1       (c2_1),
    .C2_2       (c2_2),
    .C2_3       (c2_3),
    .C2_5       (c2_5),
    .C2_6       (c2_6),
    .C2_8       (c2_8),
    .PAD1_VALID (v1),
    .PAD2_VALID (v2),
    .FRAME_STB  (stb)
  );

  // {Cx_8, Cx_6, Cx_5, Cx_3, Cx_2, Cx_1, Cx_0}
  logic [6:0] c1_v, c2_v;
  assign c1_v = {c1_8, c1_6, c1_5, c1_3, c1_2, c1_1, c1_0};
  assign c2_v = {c2_8, c2_6, c2_5, c2_3, c2_2, c2_1, c2_0};

  // Behavioural SNES pad pair: latch loads, each PAD_CLK rise advances one bit.
  logic [15:0] p1_word = 16'hFFFF;
  logic [15:0] p2_word = 16'hFFFF;
  int   pad_idx = 0;
  logic pclk_prev = 1'b1;
  always @(posedge clk) begin
    pclk_prev <= pad_clk;
    if (pad_latch) pad_idx <= 0;
    else if (pad_clk && !pclk_prev && pad_idx < 16) pad_idx <= pad_idx + 1;
  end
  assign pad1_data = (pad_idx < 16) ? p1_word[pad_idx[3:0]] : 1'b1;
  assign pad2_data = (pad_idx < 16) ? p2_word[pad_idx[3:0]] : 1'b1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_stb(input string name);
    int n;
    n = 0;
    while (stb !== 1'b1 && n < 2 * Poll) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " strobe"}, 32'(stb), 32'd1);
    @(posedge clk); #1;
    check({name, " strobe width"}, 32'(stb), 32'd0);
  endtask

  task automatic run_len(input bit pick_clk, input logic lvl, output int len);
    len = 0;
    while (((pick_clk ? pad_clk : pad_latch) === lvl) && stb !== 1'b1 && len < 4 * Poll) begin
      len++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit          frame;
    logic [15:0] w1, w2;
    logic        s14, s17, s24, s27;
    logic [6:0]  e1, e2;
    logic        ev1, ev2;
  } vec_t;

  vec_t vecs[12];
  int   n, len, falls;
  logic bad, prev;

  initial begin
    vecs[0]  = '{1, 16'hFFEE, 16'hFFFF, 1, 0, 1, 0, 7'h6E, 7'h7F, 1, 1};
    vecs[1]  = '{0, 16'hFFEE, 16'hFFFF, 0, 1, 1, 0, 7'h7F, 7'h7F, 1, 1};
    vecs[2]  = '{0, 16'hFFEE, 16'hFFFF, 0, 0, 1, 0, 7'h7F, 7'h7F, 1, 1};
    vecs[3]  = '{1, 16'hFEF3, 16'hFEF3, 0, 1, 0, 1, 7'h6D, 7'h6D, 1, 1};
    vecs[4]  = '{0, 16'hFEF3, 16'hFEF3, 1, 0, 1, 0, 7'h7F, 7'h7F, 1, 1};
    vecs[5]  = '{0, 16'hFEF3, 16'hFEF3, 0, 1, 0, 1, 7'h6D, 7'h6D, 1, 1};
    vecs[6]  = '{1, 16'hFEFB, 16'hFEF3, 0, 1, 0, 1, 7'h67, 7'h6D, 1, 1};
    vecs[7]  = '{1, 16'hFF8F, 16'hFEF3, 1, 0, 0, 1, 7'h7B, 7'h6D, 1, 1};
    vecs[8]  = '{1, 16'hFF8F, 16'h0000, 1, 0, 1, 0, 7'h7B, 7'h7F, 1, 0};
    vecs[9]  = '{0, 16'hFF8F, 16'h0000, 1, 0, 0, 1, 7'h7B, 7'h7F, 1, 0};
    vecs[10] = '{0, 16'hFF8F, 16'h0000, 1, 1, 1, 1, 7'h7F, 7'h7F, 1, 0};
    vecs[11] = '{1, 16'hFF8F, 16'hFFEE, 1, 0, 1, 0, 7'h7B, 7'h6E, 1, 1};

    c1_4 = 1'b1; c1_7 = 1'b0; c2_4 = 1'b1; c2_7 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset c1", 32'(c1_v), 32'h7F);
    check("reset c2", 32'(c2_v), 32'h7F);
    check("reset latch", 32'(pad_latch), 32'd0);
    check("reset padclk", 32'(pad_clk), 32'd1);
    check("reset valids", 32'({v1, v2}), 32'd0);
    check("reset stb", 32'(stb), 32'd0);

    // First frame timing.
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    bad = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!pad_latch && (c1_v !== 7'h7F || c2_v !== 7'h7F || pad_clk !== 1'b1)) bad = 1'b1;
    end while (pad_latch !== 1'b1 && n < 2 * Poll);
    check("idle outputs before frame 1", 32'(bad), 32'd0);
    check("first latch delay", n, Poll);
    run_len(1'b0, 1'b1, len);
    check("latch width", len, Latch);
    for (int k = 1; k <= 15; k++) begin
      run_len(1'b1, 1'b0, len);
      check($sformatf("clk lo %0d", k), len, Half);
      run_len(1'b1, 1'b1, len);
      check($sformatf("clk hi %0d", k), len, Half);
    end
    check("stb after last hi", 32'(stb), 32'd1);
    @(posedge clk); #1;
    check("stb one cycle", 32'(stb), 32'd0);

    // Table of frames and select toggles.
    for (int i = 0; i < 12; i++) begin
      p1_word = vecs[i].w1;
      p2_word = vecs[i].w2;
      c1_4 = vecs[i].s14; c1_7 = vecs[i].s17;
      c2_4 = vecs[i].s24; c2_7 = vecs[i].s27;
      if (vecs[i].frame) wait_stb($sformatf("vec %0d", i));
      #1;
      check($sformatf("vec %0d c1", i), 32'(c1_v), 32'(vecs[i].e1));
      check($sformatf("vec %0d c2", i), 32'(c2_v), 32'(vecs[i].e2));
      check($sformatf("vec %0d valid", i), 32'({v1, v2}), 32'({vecs[i].ev1, vecs[i].ev2}));
    end

    // Mid-frame reset during bit 7 low phase.
    p1_word = 16'hFFEE;
    c1_4 = 1'b1; c1_7 = 1'b0;
    wait_stb("pre-reset frame");
    check("pre-reset c1", 32'(c1_v), 32'h6E);
    n = 0;
    while (pad_latch !== 1'b1 && n < 2 * Poll) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre-reset latch seen", 32'(pad_latch), 32'd1);
    falls = 0;
    prev = pad_clk;
    n = 0;
    while (falls < 7 && n < 2 * Poll) begin
      @(posedge clk); #1;
      n++;
      if (prev && !pad_clk) falls++;
      prev = pad_clk;
    end
    check("bit 7 low phase reached", falls, 7);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset padclk", 32'(pad_clk), 32'd1);
    check("async reset latch", 32'(pad_latch), 32'd0);
    check("async reset c1", 32'(c1_v), 32'h7F);
    check("async reset valids", 32'({v1, v2}), 32'd0);
    check("async reset stb", 32'(stb), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    bad = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (stb === 1'b1 || c1_v !== 7'h7F) bad = 1'b1;
    end while (pad_latch !== 1'b1 && n < 2 * Poll);
    check("no commit after reset", 32'(bad), 32'd0);
    check("latch delay after reset", n, Poll);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/porta_pad_serial.md
Name: porta_pad_serial

Overview:
- Upstream input stage for the portable's controller path: polls two SNES-style serial gamepads and produces the Coleco-style active-low controller lines C1_*/C2_* that the glue logic consumes.
- The glue drives the select commons (Cx_4 = keypad/arm, Cx_7 = joystick/fire). This block muxes registered button state onto Cx_0..Cx_3 and Cx_5 according to those selects.
- This replaces the physical Coleco joystick hardware on the portable board.

Parameters:
- POLL_CYCLES, 59659: clk cycles between frame starts (60 Hz at 3.579545 MHz). Must exceed the frame length (elaboration check).
- LATCH_CYCLES, 43: clk cycles PAD_LATCH is held high (about 12 us).
- HALF_CYCLES, 22: clk cycles per PAD_CLK half-period (about 6 us).

Ports:
- clk  in  1  system clock, all logic on posedge.
- RESETn  in  1  reset. One clock; reset is asynchronous and active-low.
- PAD_LATCH  out  1  latch pulse shared by both pads, active-high.
- PAD_CLK  out  1  shift clock shared by both pads, idles high.
- PAD1_DATA  in  1  pad 1 serial data, active-low, asynchronous.
- PAD2_DATA  in  1  pad 2 serial data, active-low, asynchronous.
- C1_4, C2_4  in  1  keypad-select common from glue, active-low.
- C1_7, C2_7  in  1  joystick-select common from glue, active-low.
- C1_0..C1_3, C1_5, C1_6, C1_8  out  1 each  player 1 controller lines, active-low.
- C2_0..C2_3, C2_5, C2_6, C2_8  out  1 each  player 2 controller lines, active-low.
- PAD1_VALID, PAD2_VALID  out  1  last committed frame was well-formed.
- FRAME_STB  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset (async, active-low):
  - FSM to IDLE; poll counter to 0.
  - PAD_LATCH=0, PAD_CLK=1.
  - Both button registers = all released. All Cx outputs = 1.
  - VALIDs=0, FRAME_STB=0.
  - A reset mid-frame aborts the frame with no commit.
- Input sync: PADx_DATA pass through 2-flop synchronizers before use.
- Poll counter: free-runs 0..POLL_CYCLES-1. The wrap to 0 starts a frame, so the first frame begins POLL_CYCLES cycles after reset release.
- FSM states and transitions:
  - IDLE: hold PAD_LATCH=0, PAD_CLK=1 until the poll wrap, then go to LATCH.
  - LATCH: PAD_LATCH=1 for LATCH_CYCLES cycles. On the last cycle, shift in synced bit 0 (B) for both pads. Then go to CLK_LO with bit counter = 1.
  - CLK_LO: PAD_CLK=0 for HALF_CYCLES cycles, then go to CLK_HI.
  - CLK_HI: PAD_CLK=1 for HALF_CYCLES cycles. On the last cycle, shift in bit n. If n=15, go to DONE; otherwise n+1 and go to CLK_LO.
  - DONE (1 cycle): commit both shadow registers, pulse FRAME_STB, go to IDLE.
- Frame length: LATCH_CYCLES + 30*HALF_CYCLES + 1 cycles.
- Bit order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then 4 id bits. Data is low = pressed.
- Commit rule:
  - Id bits 12..15 all 1: VALID=1 and the button register takes the shadow value.
  - Otherwise (absent or faulty pad): VALID=0 and the button register is forced all released.
  - Button registers change only at commit, so they are atomic per frame.
- SOCD: Up+Down both pressed commits both released; likewise Left+Right.
- Output mux (combinational from registered state and the selects, zero latency):
  - Cx_7=0 and Cx_4=1 (joystick): Cx_0=Up_n, Cx_1=Down_n, Cx_2=Left_n, Cx_3=Right_n, Cx_5=B_n.
  - Cx_4=0 and Cx_7=1 (keypad): {Cx_3..Cx_0}=key code, Cx_5=A_n.
    - Start pressed: KEY_START=4'b1101.
    - Else Select pressed: KEY_SELECT=4'b0111.
    - Else 4'b1111.
  - Both selects low or both high: Cx_0..Cx_3, Cx_5 = 1.
  - Cx_6 and Cx_8 are constant 1.
- Y, X, L, R are captured but unused on outputs.

Decomposition:
- Package porta_pad_pkg holds:
  - serial bit-index constants (BIT_B..BIT_R, BIT_ID_LO=12);
  - KEY_START, KEY_SELECT, KEY_NONE;
  - the FSM state encoding (IDLE, LATCH, CLK_LO, CLK_HI, DONE).
- Sub-module porta_pad_mux implements the per-player select and keypad-encode mux. It is instantiated twice.

Test Plan:
1. Reset, then release.
   - During reset and until the first frame: all Cx outputs=1, PAD_LATCH=0, PAD_CLK=1.
   - First PAD_LATCH rise exactly POLL_CYCLES cycles after release; high for 43 cycles; then 15 PAD_CLK low/high pairs of 22/22 cycles.
   - FRAME_STB pulses 1 cycle after the last high phase.
2. Pad 1 model sends Up+B pressed with id=1111, C1_7=0, C1_4=1.
   - After FRAME_STB: C1_0=0, C1_5=0, C1_1..C1_3=1, PAD1_VALID=1.
   - Pad 2 (idle, all 1s): all C2 lines=1.
3. Pad 1 sends Start+Select+A, C1_4=0, C1_7=1.
   - {C1_3..C1_0}=1101, C1_5=0.
   - Release Start next frame: 0111.
   - Toggling the selects changes the outputs in the same cycle.
4. Pad 1 sends Up+Down+Left pressed, joystick select.
   - C1_0=1, C1_1=1, C1_2=0.
5. Pad 2 data held low for a whole frame (id=0000).
   - PAD2_VALID=0, all C2 lines=1 in any select state.
   - The following good frame restores VALID=1.
6. Assert RESETn mid-CLK_LO of bit 7.
   - Outputs go to reset values immediately (async).
   - No FRAME_STB; previously committed buttons are cleared.
   - The next frame starts POLL_CYCLES after release.
